// File: rtl/cam_subarray_write_responder_if.sv
// Write-request bus between the write sequencer (master) and the CAM subarray
// write responder (slave).
interface cam_subarray_write_responder_if;
   logic [15:0] chip_enable;
   logic [9:0]  cmp_addr;
   logic [15:0] data_in;
   logic        write_ack;
   logic        busy;
   logic        err_onehot;

   modport master (
      output chip_enable, cmp_addr, data_in,
      input  write_ack, busy, err_onehot
   );

   modport slave (
      input  chip_enable, cmp_addr, data_in,
      output write_ack, busy, err_onehot
   );
endinterface

// File: rtl/cam_subarray_write_responder.sv
// CAM subarray write responder: 16x32 {valid, tag, data} store with latency-programmed
// commit, one-shot ack per request and a debug read port. Define CAM_WR_VERIFY_EN for read-back verify.
module cam_subarray_write_responder #(
   parameter int WR_LAT = 2
) (
   input  logic                                 CLK,
   input  logic                                 rst,
   cam_subarray_write_responder_if.slave        wr,
   input  logic [3:0]                           rd_sel,
   input  logic [4:0]                           rd_addr,
   output logic [15:0]                          rd_data,
   output logic                                 rd_valid,
   output logic [4:0]                           rd_tag
);

`ifdef CAM_WR_VERIFY_EN
   typedef enum logic [1:0] {IDLE, PROGRAM, ACK, VERIFY} state_t;
`else
   typedef enum logic [1:0] {IDLE, PROGRAM, ACK} state_t;
`endif

   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

   state_t      state;
   logic [2:0]  cnt;
   logic [3:0]  sub_q;
   logic [9:0]  addr_q;
   logic [15:0] data_q;
   logic        last_valid;
   logic [3:0]  last_sub;
   logic [9:0]  last_addr;

   logic [20:0] mem [16][32];
   logic [31:0] valid_q [16];

   logic        ce_zero;
   logic        ce_onehot;
   logic [3:0]  ce_idx;
   logic        new_pair;
   logic        commit;
   logic        rd_hit;

   assign ce_zero   = (wr.chip_enable == 16'h0000);
   assign ce_onehot = $onehot(wr.chip_enable);
   assign ce_idx    = onehot_to_idx(wr.chip_enable);
   // A held request is only new once the sequencer has dropped enable or moved on.
   assign new_pair  = !last_valid || (ce_idx != last_sub) || (wr.cmp_addr != last_addr);
   assign commit    = (state == PROGRAM) && (cnt == 3'd0);
   assign rd_hit    = commit && (sub_q == rd_sel) && (addr_q[4:0] == rd_addr);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= 3'd0;
         sub_q         <= 4'd0;
         addr_q        <= 10'd0;
         data_q        <= 16'd0;
         last_valid    <= 1'b0;
         last_sub      <= 4'd0;
         last_addr     <= 10'd0;
         wr.write_ack  <= 1'b0;
         wr.busy       <= 1'b0;
         wr.err_onehot <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr.write_ack <= 1'b0;
               if (ce_zero) begin
                  last_valid <= 1'b0;
               end else if (!ce_onehot) begin
                  wr.err_onehot <= 1'b1;
               end else if (new_pair) begin
                  sub_q   <= ce_idx;
                  addr_q  <= wr.cmp_addr;
                  data_q  <= wr.data_in;
                  cnt     <= 3'(WR_LAT - 1);
                  wr.busy <= 1'b1;
                  state   <= PROGRAM;
               end
            end
            PROGRAM: begin
               if (cnt == 3'd0) begin
`ifdef CAM_WR_VERIFY_EN
                  state <= VERIFY;
`else
                  wr.write_ack <= 1'b1;
                  state        <= ACK;
`endif
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
`ifdef CAM_WR_VERIFY_EN
            VERIFY: begin
               if (valid_q[sub_q][addr_q[4:0]] &&
                   (mem[sub_q][addr_q[4:0]] == {addr_q[9:5], data_q})) begin
                  wr.write_ack <= 1'b1;
                  state        <= ACK;
               end else begin
                  wr.err_onehot <= 1'b1;
                  wr.busy       <= 1'b0;
                  state         <= IDLE;
               end
            end
`endif
            ACK: begin
               wr.write_ack <= 1'b0;
               wr.busy      <= 1'b0;
               last_valid   <= 1'b1;
               last_sub     <= sub_q;
               last_addr    <= addr_q;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the tag/data array has no reset so it can map onto RAM; only the
   // valid bits are reset, which is enough to make stale contents invisible.
   always_ff @(posedge CLK) begin
      if (commit) mem[sub_q][addr_q[4:0]] <= {addr_q[9:5], data_q};
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         valid_q <= '{default: '0};
      end else if (commit) begin
         valid_q[sub_q][addr_q[4:0]] <= 1'b1;
      end
   end

   // Write-first debug read: a commit to the entry being read is forwarded directly.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         rd_data  <= 16'd0;
         rd_valid <= 1'b0;
         rd_tag   <= 5'd0;
      end else if (rd_hit) begin
         rd_data  <= data_q;
         rd_valid <= 1'b1;
         rd_tag   <= addr_q[9:5];
      end else begin
         rd_data  <= mem[rd_sel][rd_addr][15:0];
         rd_valid <= valid_q[rd_sel][rd_addr];
         rd_tag   <= mem[rd_sel][rd_addr][20:16];
      end
   end

endmodule

// File: tb/tb_cam_subarray_write_responder.sv
// Directed, table-driven bench for cam_subarray_write_responder (WR_LAT=2); honours CAM_WR_VERIFY_EN.
module tb_cam_subarray_write_responder;

   localparam int WR_LAT = 2;
`ifdef CAM_WR_VERIFY_EN
   localparam int ACK_LAT = WR_LAT + 1;
`else
   localparam int ACK_LAT = WR_LAT;
`endif

   typedef struct {
      logic [15:0] ce;
      logic [9:0]  addr;
      logic [15:0] data;
      logic [3:0]  sel;
      logic [4:0]  entry;
      logic [4:0]  tag;
   } vec_t;

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rd_sel = '0;
   logic [4:0]  rd_addr = '0;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [4:0]  rd_tag;

   int n_cmp  = 0;
   int n_fail = 0;

   cam_subarray_write_responder_if wr ();

   cam_subarray_write_responder #(.WR_LAT(WR_LAT)) u_dut (
      .CLK      (CLK),
      .rst      (rst),
      .wr       (wr.slave),
      .rd_sel   (rd_sel),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Watches `window` edges from the capture edge; reports ack latency (-1 if none) and pulse count.
   task automatic wait_ack(input int window, output int lat, output int pulses);
      lat = -1;
      pulses = 0;
      for (int k = 1; k <= window; k++) begin
         @(posedge CLK); #1;
         if (k == 1) check("busy_after_capture", 32'(wr.busy), 32'd1);
         if (wr.write_ack) begin
            if (lat < 0) lat = k - 1;
            pulses++;
         end
      end
   endtask

   task automatic write_req(input logic [15:0] ce, input logic [9:0] addr, input logic [15:0] data,
                            output int lat, output int pulses);
      @(negedge CLK);
      wr.chip_enable = ce;
      wr.cmp_addr    = addr;
      wr.data_in     = data;
      wait_ack(ACK_LAT + 6, lat, pulses);
      check("busy_after_ack", 32'(wr.busy), 32'd0);
      @(negedge CLK);
      wr.chip_enable = '0;
      @(posedge CLK);
   endtask

   task automatic dbg_read(input logic [3:0] sel, input logic [4:0] entry);
      @(negedge CLK);
      rd_sel  = sel;
      rd_addr = entry;
      @(posedge CLK); #1;
   endtask

   vec_t vecs [19];
   int   lat, pulses;
   int   ack_seen, busy_seen;

   initial begin
      vecs[0] = '{16'h0001, 10'h040, 16'hBEEF, 4'd0, 5'd0, 5'd2};
      for (int i = 0; i < 16; i++)
         vecs[1 + i] = '{16'(32'h1 << i), 10'h000, 16'(32'h1000 + i), 4'(i), 5'd0, 5'd0};
      vecs[17] = '{16'h8000, 10'h3FF, 16'hFFFF, 4'd15, 5'd31, 5'd31};
      vecs[18] = '{16'h0100, 10'h2A5, 16'h1234, 4'd8, 5'd5, 5'd21};

      wr.chip_enable = '0;
      wr.cmp_addr    = '0;
      wr.data_in     = '0;

      // Reset state
      #2 rst = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_write_ack", 32'(wr.write_ack), 32'd0);
      check("rst_busy", 32'(wr.busy), 32'd0);
      check("rst_err_onehot", 32'(wr.err_onehot), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_tag", 32'(rd_tag), 32'd0);
      @(negedge CLK);
      rst = 1'b1;

      // Non-one-hot enable: sticky error, no write, no ack, stays idle
      @(negedge CLK);
      wr.chip_enable = 16'h0003;
      wr.data_in     = 16'h1111;
      ack_seen  = 0;
      busy_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge CLK); #1;
         if (wr.write_ack) ack_seen++;
         if (wr.busy) busy_seen++;
      end
      check("onehot_err_no_ack", 32'(ack_seen), 32'd0);
      check("onehot_err_no_busy", 32'(busy_seen), 32'd0);
      check("onehot_err_flag", 32'(wr.err_onehot), 32'd1);
      @(negedge CLK);
      wr.chip_enable = '0;
      dbg_read(4'd0, 5'd0);
      check("onehot_err_sub0_valid", 32'(rd_valid), 32'd0);
      dbg_read(4'd1, 5'd0);
      check("onehot_err_sub1_valid", 32'(rd_valid), 32'd0);

      // Table of writes, each read back immediately
      for (int i = 0; i < 19; i++) begin
         write_req(vecs[i].ce, vecs[i].addr, vecs[i].data, lat, pulses);
         check($sformatf("vec%0d_ack_latency", i), 32'(lat), 32'(ACK_LAT));
         check($sformatf("vec%0d_ack_pulses", i), 32'(pulses), 32'd1);
         dbg_read(vecs[i].sel, vecs[i].entry);
         check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].data));
         check($sformatf("vec%0d_rd_tag", i), 32'(rd_tag), 32'(vecs[i].tag));
         check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'd1);
      end

      // Entry 0 of every subarray still holds its own 0x1000+i
      for (int i = 0; i < 16; i++) begin
         dbg_read(4'(i), 5'd0);
         check($sformatf("sweep_sub%0d_data", i), 32'(rd_data), 32'(32'h1000 + i));
         check($sformatf("sweep_sub%0d_valid", i), 32'(rd_valid), 32'd1);
      end
      check("err_onehot_sticky", 32'(wr.err_onehot), 32'd1);

      // Held pair acks once; one idle zero cycle re-arms the identical pair
      @(negedge CLK);
      wr.chip_enable = 16'h0010;
      wr.cmp_addr    = 10'h007;
      wr.data_in     = 16'hA0A0;
      wait_ack(ACK_LAT + 12, lat, pulses);
      check("held_ack_latency", 32'(lat), 32'(ACK_LAT));
      check("held_ack_pulses", 32'(pulses), 32'd1);
      @(negedge CLK);
      wr.chip_enable = '0;
      @(negedge CLK);
      wr.chip_enable = 16'h0010;
      wr.data_in     = 16'hA0A1;
      wait_ack(ACK_LAT + 6, lat, pulses);
      check("rearm_ack_latency", 32'(lat), 32'(ACK_LAT));
      check("rearm_ack_pulses", 32'(pulses), 32'd1);
      @(negedge CLK);
      wr.chip_enable = '0;
      dbg_read(4'd4, 5'd7);
      check("rearm_rd_data", 32'(rd_data), 32'hA0A1);

      // Reset one cycle into PROGRAM aborts the write
      @(negedge CLK);
      wr.chip_enable = 16'h0400;
      wr.cmp_addr    = 10'h00C;
      wr.data_in     = 16'hDEAD;
      @(posedge CLK); #1;
      check("abort_busy_captured", 32'(wr.busy), 32'd1);
      @(negedge CLK);
      rst = 1'b0;
      wr.chip_enable = '0;
      #1;
      check("abort_busy_async", 32'(wr.busy), 32'd0);
      check("abort_err_cleared", 32'(wr.err_onehot), 32'd0);
      @(posedge CLK); #1;
      check("abort_no_ack", 32'(wr.write_ack), 32'd0);
      @(negedge CLK);
      rst = 1'b1;
      wr.chip_enable = 16'h0400;
      wr.cmp_addr    = 10'h00D;
      wr.data_in     = 16'hCAFE;
      wait_ack(ACK_LAT + 6, lat, pulses);
      check("post_rst_ack_latency", 32'(lat), 32'(ACK_LAT));
      check("post_rst_ack_pulses", 32'(pulses), 32'd1);
      @(negedge CLK);
      wr.chip_enable = '0;
      dbg_read(4'd10, 5'd12);
      check("abort_entry_valid", 32'(rd_valid), 32'd0);
      dbg_read(4'd10, 5'd13);
      check("post_rst_rd_data", 32'(rd_data), 32'hCAFE);
      check("post_rst_rd_valid", 32'(rd_valid), 32'd1);
      dbg_read(4'd0, 5'd0);
      check("rst_cleared_old_valid", 32'(rd_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_subarray_write_responder.md
CAM_SUBARRAY_WRITE_RESPONDER -- requirements
Module: cam_subarray_write_responder

Interface
REQ-001 Parameter WR_LAT, default 2, program latency in cycles from request capture to array commit; legal 1..7.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 chip_enable  input  16  one-hot subarray select from write sequencer; all-zero = no request.
REQ-005 cmp_addr  input  10  write address; [4:0] entry index within subarray, [9:5] bank tag.
REQ-006 data_in  input  16  write data.
REQ-007 write_ack  output  1  single-cycle pulse: addressed entry committed.
REQ-008 busy  output  1  high while a request is in service.
REQ-009 err_onehot  output  1  sticky; set when a non-zero, non-one-hot chip_enable is presented.
REQ-010 rd_sel  input  4  debug read subarray select.
REQ-011 rd_addr  input  5  debug read entry index.
REQ-012 rd_data  output  16  registered debug read data, 1-cycle latency.
REQ-013 rd_valid  output  1  registered valid bit of the entry read, same timing as rd_data.
REQ-014 rd_tag  output  5  registered bank tag stored with the entry read.

Function
REQ-015 Storage: 16 subarrays x 32 entries, each {valid, tag[4:0], data[15:0]}.
REQ-016 States: IDLE, PROGRAM, ACK (plus VERIFY when REQ-030 enabled); encoding free.
REQ-017 New request in IDLE: chip_enable one-hot AND ({chip_enable, cmp_addr} differs from last-served pair OR last-served cleared).
REQ-018 On new request at edge E0: latch subarray index (encoded one-hot), cmp_addr, data_in; load counter with WR_LAT-1; enter PROGRAM; busy=1 from E0.
REQ-019 PROGRAM: decrement each cycle; inputs ignored; when counter=0, commit {1, tag, data} to latched subarray/entry at next edge and enter ACK.
REQ-020 write_ack high exactly the cycle after commit; commit edge = E0+WR_LAT; write_ack high from E0+WR_LAT to E0+WR_LAT+1.
REQ-021 ACK: record last-served pair, drop busy, return to IDLE at next edge; a new request is accepted no earlier than the following edge.
REQ-022 chip_enable all-zero seen in IDLE clears last-served, allowing an identical pair to be rewritten.
REQ-023 Same pair held after ACK produces no second write or ack (sequencer holds chip_enable through its WAIT_ACK->WRITE turnaround).
REQ-024 Non-one-hot non-zero chip_enable in IDLE: set err_onehot, no write, no ack, stay IDLE; err_onehot cleared only by reset.
REQ-025 Rewriting a valid entry overwrites data and tag; no error.
REQ-026 Debug read port independent of state; a debug read of the entry committed at edge N returns new data at edge N+1 (write-first).

Reset
REQ-027 rst low: immediately state=IDLE, write_ack=0, busy=0, err_onehot=0, rd_data=0, rd_valid=0, rd_tag=0, counter=0, last-served cleared, all 512 valid bits cleared.
REQ-028 Reset during PROGRAM aborts: no commit, no ack; data/tag storage need not be cleared.
REQ-029 First request is accepted at the first rising edge after rst deasserts.

Configuration
REQ-030 Macro CAM_WR_VERIFY_EN defined: after commit, enter VERIFY for 1 cycle, read back entry; match -> ACK (write_ack one cycle later, at E0+WR_LAT+1); mismatch -> set err_onehot, no ack, return to IDLE.
REQ-031 CAM_WR_VERIFY_EN undefined: no VERIFY state, timing exactly per REQ-020.

Verification
REQ-032 WR_LAT=2, chip_enable=0x0001, cmp_addr=0x040, data_in=0xBEEF at E0 -> write_ack pulse E0+2..E0+3; rd_sel=0, rd_addr=0 -> rd_data=0xBEEF, rd_tag=2, rd_valid=1.
REQ-033 Sequence of 16 one-hot enables 0x0001..0x8000, each held until ack, data=0x1000+i -> 16 acks, subarray i entry 0 = 0x1000+i.
REQ-034 chip_enable=0x0003 -> err_onehot=1, no write_ack, busy stays 0, subarray 0/1 entry 0 valid stays 0.
REQ-035 chip_enable=0x0010 held 10 cycles after ack -> exactly one ack; drop to 0x0000 one cycle then reassert -> second ack.
REQ-036 rst low one cycle after request capture -> no ack, entry valid=0; after release, new request acked at E0+WR_LAT.
REQ-037 With CAM_WR_VERIFY_EN, WR_LAT=2 write 0x5A5A -> write_ack at E0+3 only, rd_data=0x5A5A.
